r_type_exec_top: RTL and testbench

- Single-cycle MIPS R-type execution slice: a 32x32 register file plus an ALU.
- Decodes the instruction word I, reads rs/rt combinationally, computes the ALU result, and writes it to rd on the rising clock edge.
- Top level of the datapath experiment; the instruction is driven externally (no PC or instruction memory).

---
 rtl/r_type_exec_top_pkg.sv | 19 +
 rtl/r_type_exec_top_regfile.sv | 27 ++
 rtl/r_type_exec_top.sv | 50 +++++
 tb/tb_r_type_exec_top.sv | 103 ++++++++++
 4 files changed

// File: rtl/r_type_exec_top_pkg.sv
// r_type_exec_top_pkg: shared widths, opcode and funct codes for the R-type slice
package r_type_exec_top_pkg;
   localparam int WIDTH = 32;
   localparam int NREG = 32;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;
endpackage

// File: rtl/r_type_exec_top_regfile.sv
// r_type_exec_top_regfile: 2-read/1-write register file, async reset-to-index, r0 reads 0
module r_type_exec_top_regfile
   import r_type_exec_top_pkg::*;
#(
   parameter int W = WIDTH,
   parameter int N = NREG
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [$clog2(N)-1:0] ra1,
   input  logic [$clog2(N)-1:0] ra2,
   input  logic [$clog2(N)-1:0] wa,
   input  logic                 we,
   input  logic [W-1:0]         wd,
   output logic [W-1:0]         rd1,
   output logic [W-1:0]         rd2
);
   logic [W-1:0] regs [N];
   // regs[0] resets to 0 and is never written, reads are also gated for safety
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < N; i++) regs[i] <= W'(i);
      else if (we && wa != '0)
         regs[wa] <= wd;
   assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
endmodule

// File: rtl/r_type_exec_top.sv
// r_type_exec_top: single-cycle MIPS R-type slice, decode + combinational ALU + register write-back
module r_type_exec_top
   import r_type_exec_top_pkg::*;
#(
   parameter int WIDTH = r_type_exec_top_pkg::WIDTH,
   parameter int NREG = r_type_exec_top_pkg::NREG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      I,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result
);
   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd, shamt;
   logic       ok;
   assign op    = I[31:26];
   assign rs    = I[25:21];
   assign rt    = I[20:16];
   assign rd    = I[15:11];
   assign shamt = I[10:6];
   assign funct = I[5:0];
   r_type_exec_top_regfile #(.W(WIDTH), .N(NREG)) u_rf (
      .clk(clk), .rst(rst),
      .ra1(rs), .ra2(rt), .wa(rd),
      .we(ok && op == OP_RTYPE), .wd(result),
      .rd1(A), .rd2(B)
   );
   // ok clears on unsupported funct so the result is 0 and nothing is written
   always_comb begin
      ok = 1'b1;
      result = '0;
      case (funct)
         FN_ADD, FN_ADDU: result = A + B;
         FN_SUB, FN_SUBU: result = A - B;
         FN_AND:  result = A & B;
         FN_OR:   result = A | B;
         FN_XOR:  result = A ^ B;
         FN_NOR:  result = ~(A | B);
         FN_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
         FN_SLTU: result = {{(WIDTH-1){1'b0}}, A < B};
         FN_SLL:  result = B << shamt;
         FN_SRL:  result = B >> shamt;
         FN_SRA:  result = $signed(B) >>> shamt;
         default: ok = 1'b0;
      endcase
      if (op != OP_RTYPE) result = '0;
   end
endmodule

// File: tb/tb_r_type_exec_top.sv
// tb_r_type_exec_top: directed scoreboard bench for the R-type execution slice
module tb_r_type_exec_top;
   import r_type_exec_top_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] I = '0;
   logic [31:0] A, B, result;
   int passed = 0, failed = 0, total = 0;
   typedef struct {
      string tag;
      logic [31:0] a, b, r;
   } exp_t;
   exp_t sb[$];

   r_type_exec_top dut (.clk(clk), .rst(rst), .I(I), .A(A), .B(B), .result(result));

   always #5 clk = ~clk;

   function automatic logic [31:0] ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                       logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
      return {op, rs, rt, rd, sh, fn};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run(string tag, logic [31:0] instr, logic [31:0] ea, logic [31:0] eb, logic [31:0] er);
      exp_t e;
      I = instr;
      sb.push_back('{tag, ea, eb, er});
      #1;
      e = sb.pop_front();
      chk({e.tag, ".A"}, A, e.a);
      chk({e.tag, ".B"}, B, e.b);
      chk({e.tag, ".result"}, result, e.r);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      run("rst_add7", ins(0, 5, 31, 7, 0, FN_ADD), 32'd5, 32'd31, 32'd36);
      step();
      rst = 1'b0;
      run("rst_nowrite7", ins(0, 7, 0, 0, 0, FN_OR), 32'd7, 32'd0, 32'd7);
      run("add16", 32'h01AB8020, 32'd13, 32'd11, 32'd24);
      step();
      run("rd16", 32'h02000020, 32'd24, 32'd0, 32'd24);
      run("sub17", 32'h01C98822, 32'd14, 32'd9, 32'd5);
      step();
      run("and18", 32'h01EA9024, 32'd15, 32'd10, 32'd10);
      step();
      run("rd17", ins(0, 17, 18, 0, 0, FN_ADD), 32'd5, 32'd10, 32'd15);
      run("or19", 32'h030B9825, 32'd24, 32'd11, 32'd27);
      step();
      run("slt20", 32'h032CA02A, 32'd25, 32'd12, 32'd0);
      step();
      run("rd20", ins(0, 20, 19, 0, 0, FN_ADD), 32'd0, 32'd27, 32'd27);
      run("sub1", ins(0, 0, 5, 1, 0, FN_SUB), 32'd0, 32'd5, 32'hFFFF_FFFB);
      step();
      run("slt2", ins(0, 1, 0, 2, 0, FN_SLT), 32'hFFFF_FFFB, 32'd0, 32'd1);
      step();
      run("sltu3", ins(0, 1, 0, 3, 0, FN_SLTU), 32'hFFFF_FFFB, 32'd0, 32'd0);
      step();
      run("sra4", ins(0, 0, 1, 4, 1, FN_SRA), 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFD);
      step();
      run("rd2_3", ins(0, 2, 3, 0, 0, FN_OR), 32'd1, 32'd0, 32'd1);
      run("rd4", ins(0, 4, 0, 0, 0, FN_OR), 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFD);
      run("srl", ins(0, 0, 1, 0, 4, FN_SRL), 32'd0, 32'hFFFF_FFFB, 32'h0FFF_FFFF);
      run("sll", ins(0, 0, 13, 0, 3, FN_SLL), 32'd0, 32'd13, 32'd104);
      run("xor", ins(0, 14, 9, 0, 0, FN_XOR), 32'd14, 32'd9, 32'd7);
      run("nor", ins(0, 0, 0, 0, 0, FN_NOR), 32'd0, 32'd0, 32'hFFFF_FFFF);
      run("addu_wrap", ins(0, 1, 5, 0, 0, FN_ADDU), 32'hFFFF_FFFB, 32'd5, 32'd0);
      run("subu_wrap", ins(0, 5, 13, 0, 0, FN_SUBU), 32'd5, 32'd13, 32'hFFFF_FFF8);
      run("add_rd0", ins(0, 13, 11, 0, 0, FN_ADD), 32'd13, 32'd11, 32'd24);
      step();
      run("r0_zero", ins(0, 0, 0, 0, 0, FN_ADD), 32'd0, 32'd0, 32'd0);
      run("op_nonr", ins(6'h23, 13, 11, 16, 0, FN_ADD), 32'd13, 32'd11, 32'd0);
      step();
      run("rd16_kept", ins(0, 16, 0, 0, 0, FN_OR), 32'd24, 32'd0, 32'd24);
      run("bad_funct", ins(0, 13, 11, 17, 0, 6'h3F), 32'd13, 32'd11, 32'd0);
      step();
      run("rd17_kept", ins(0, 17, 0, 0, 0, FN_OR), 32'd5, 32'd0, 32'd5);
      rst = 1'b1;
      run("async_rst", ins(0, 16, 1, 18, 0, FN_ADD), 32'd16, 32'd1, 32'd17);
      run("async_rst2", ins(0, 20, 4, 0, 0, FN_OR), 32'd20, 32'd4, 32'd20);
      I = ins(0, 13, 11, 18, 0, FN_ADD);
      step();
      rst = 1'b0;
      run("rd18_rst", ins(0, 18, 17, 0, 0, FN_OR), 32'd18, 32'd17, 32'd19);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
